// File: rtl/data_mem_responder.sv
// data_mem_responder: slave end of the MEM-stage data-memory port. Takes one
// load/store at a time, stalls for a fixed number of wait states, performs the
// access on a local word array with byte-lane enables, then presents the
// result on a valid/ready response channel until the requester takes it.
module data_mem_responder #(
   parameter int data_width      = 32,
   parameter int data_words      = 512,
   parameter int data_addr_width = 9,
   parameter int wait_states     = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_we,
   input  logic [data_addr_width-1:0]   req_addr,
   input  logic [data_width-1:0]        req_wdata,
   input  logic [data_width/8-1:0]      req_be,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [data_width-1:0]        rsp_rdata,
   output logic                         rsp_we,
   output logic                         busy
);

   localparam int         NB  = data_width / 8;
   localparam logic [3:0] WS4 = 4'(wait_states);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]                 state;
   logic [3:0]                 cnt;

   // captured request, held while the access is in flight
   logic                       we_p0;
   logic [data_addr_width-1:0] addr_p0;
   logic [data_width-1:0]      wdata_p0;
   logic [NB-1:0]              be_p0;

   logic [data_width-1:0]      mem [data_words];

   logic                       accept;
   logic                       do_access;

   // A new request may enter while idle, or in the same edge the current
   // response retires; this is the only combinational path (from rsp_ready).
   assign req_ready = (state == IDLE) | ((state == RESP) & rsp_ready);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign accept    = req_valid & req_ready;
   assign do_access = (state == WAIT) & (cnt == 4'd0);

   // Control, request capture and response registers; reset drops any pending access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         we_p0     <= 1'b0;
         addr_p0   <= '0;
         wdata_p0  <= '0;
         be_p0     <= '0;
         rsp_rdata <= '0;
         rsp_we    <= 1'b0;
      end else if (accept) begin
         we_p0    <= req_we;
         addr_p0  <= req_addr;
         wdata_p0 <= req_wdata;
         be_p0    <= req_be;
         cnt      <= WS4;
         state    <= WAIT;
      end else begin
         case (state)
            IDLE: state <= IDLE;
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  rsp_we    <= we_p0;
                  rsp_rdata <= we_p0 ? '0 : mem[addr_p0];
                  state     <= RESP;
               end
            end
            RESP: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Store commit: only enabled byte lanes are written; the array is never reset.
   always_ff @(posedge clk) begin
      if (do_access && we_p0) begin
         for (int i = 0; i < NB; i++) begin
            if (be_p0[i]) mem[addr_p0][8*i +: 8] <= wdata_p0[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (2, 0 and 15 wait states)
// checked every cycle against a countdown-to-completion reference model,
// with directed scenarios plus randomized request/response traffic.
module tb_data_mem_responder;

   localparam int WS0 = 2;
   localparam int WS1 = 0;
   localparam int WS2 = 15;

   logic        clk = 1'b0;
   logic        rst       [3];
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_we    [3];
   logic [8:0]  req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_be    [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_we    [3];
   logic        busy      [3];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit done  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_responder #(.data_width(32), .data_words(512), .data_addr_width(9), .wait_states(WS0)) u0 (
      .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_we(rsp_we[0]), .busy(busy[0]));

   data_mem_responder #(.data_width(32), .data_words(512), .data_addr_width(9), .wait_states(WS1)) u1 (
      .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_we(rsp_we[1]), .busy(busy[1]));

   data_mem_responder #(.data_width(32), .data_words(512), .data_addr_width(9), .wait_states(WS2)) u2 (
      .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
      .rsp_we(rsp_we[2]), .busy(busy[2]));

   // ---------------- reference model ----------------
   // An access is "outstanding" from its accept edge until its response is
   // taken. m_rem counts edges left until the access happens (wait_states+1
   // at accept); the response is visible once it reaches zero.
   bit          m_out   [3] = '{default: 1'b0};
   int          m_rem   [3] = '{default: 0};
   logic        m_cwe   [3] = '{default: 1'b0};
   logic [8:0]  m_caddr [3] = '{default: '0};
   logic [31:0] m_cwd   [3] = '{default: '0};
   logic [3:0]  m_cbe   [3] = '{default: '0};
   logic [31:0] m_rd    [3] = '{default: '0};
   logic [31:0] m_mask  [3] = '{default: '0};
   logic        m_rwe   [3] = '{default: 1'b0};
   logic [31:0] m_mem   [3][512];
   logic [3:0]  m_known [3][512] = '{default: '{default: 4'h0}};

   function automatic int ws_of(input int k);
      return (k == 0) ? WS0 : (k == 1) ? WS1 : WS2;
   endfunction

   function automatic bit f_rv(input int k);
      return m_out[k] && (m_rem[k] == 0);
   endfunction

   function automatic bit f_rq(input int k);
      return !m_out[k] || (f_rv(k) && (rsp_ready[k] === 1'b1));
   endfunction

   function automatic logic [31:0] expand(input logic [3:0] kn);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{kn[b]}};
      return m;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst[k]) begin
            m_out[k] <= 1'b0;
         end else begin
            if (m_out[k] && m_rem[k] != 0) begin
               m_rem[k] <= m_rem[k] - 1;
               if (m_rem[k] == 1) begin
                  m_rwe[k] <= m_cwe[k];
                  if (m_cwe[k]) begin
                     m_rd[k]   <= 32'h0;
                     m_mask[k] <= 32'hFFFF_FFFF;
                     for (int b = 0; b < 4; b++) begin
                        if (m_cbe[k][b]) begin
                           m_mem[k][m_caddr[k]][8*b +: 8] <= m_cwd[k][8*b +: 8];
                           m_known[k][m_caddr[k]][b]      <= 1'b1;
                        end
                     end
                  end else begin
                     m_rd[k]   <= m_mem[k][m_caddr[k]];
                     m_mask[k] <= expand(m_known[k][m_caddr[k]]);
                  end
               end
            end else if (f_rv(k) && rsp_ready[k] === 1'b1) begin
               m_out[k] <= 1'b0;
            end
            if (f_rq(k) && req_valid[k] === 1'b1) begin
               m_out[k]   <= 1'b1;
               m_rem[k]   <= ws_of(k) + 1;
               m_cwe[k]   <= req_we[k];
               m_caddr[k] <= req_addr[k];
               m_cwd[k]   <= req_wdata[k];
               m_cbe[k]   <= req_be[k];
            end
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[u%0d] @cyc %0d: got %h expected %h", name, k, cyc, act, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         if (rst[k]) begin
            chk("req_ready", k, 32'(req_ready[k]), 32'd1);
            chk("rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
            chk("busy",      k, 32'(busy[k]),      32'd0);
         end else begin
            chk("req_ready", k, 32'(req_ready[k]), 32'(f_rq(k)));
            chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(f_rv(k)));
            chk("busy",      k, 32'(busy[k]),      32'(m_out[k]));
            if (f_rv(k)) begin
               chk("rsp_rdata", k, rsp_rdata[k] & m_mask[k], m_rd[k] & m_mask[k]);
               chk("rsp_we",    k, 32'(rsp_we[k]), 32'(m_rwe[k]));
            end
         end
      end
   endtask

   // ---------------- stimulus tasks ----------------
   task automatic send(input int k, input bit we, input logic [8:0] a, input logic [31:0] d,
                       input logic [3:0] be, output int acc);
      bit ok = 0;
      bit r;
      req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_be[k] = be; req_valid[k] = 1'b1;
      for (int c = 0; c < 60 && !ok; c++) begin
         @(negedge clk); r = (req_ready[k] === 1'b1);
         @(posedge clk); if (r) ok = 1;
      end
      #1; req_valid[k] = 1'b0; acc = cyc;
      if (!ok) chk("accept_timeout", k, 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(input int k, output int t, output logic [31:0] d, output logic w);
      bit ok = 0;
      t = 0; d = '0; w = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         if (rsp_valid[k] === 1'b1) begin ok = 1; t = cyc; d = rsp_rdata[k]; w = rsp_we[k]; end
      end
      if (!ok) chk("rsp_timeout", k, 32'd0, 32'd1);
   endtask

   task automatic access(input int k, input bit we, input logic [8:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd, output logic w, output int lat);
      int acc, t;
      send(k, we, a, d, be, acc);
      wait_rsp(k, t, rd, w);
      lat = t - acc;
      @(posedge clk); #1;
   endtask

   task automatic run_random(input int k, input int n);
      bit acc;
      for (int c = 0; c < n; c++) begin
         @(negedge clk); acc = (req_valid[k] === 1'b1) && (req_ready[k] === 1'b1);
         @(posedge clk); #1;
         if (acc || !req_valid[k]) begin
            req_valid[k] = ($urandom_range(0, 2) != 0);
            req_we[k]    = 1'($urandom_range(0, 1));
            req_addr[k]  = 9'($urandom_range(0, 7));
            req_wdata[k] = $urandom;
            req_be[k]    = 4'($urandom_range(0, 15));
         end
         rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
      repeat (25) @(posedge clk);
      #1;
   endtask

   // ---------------- directed + random sequence ----------------
   task automatic main_seq();
      logic [31:0] rd;
      logic        w;
      int          lat, acc, t, n, idx;
      int          rise [3];
      logic [31:0] dat  [3];
      bit          a2;

      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      @(negedge clk);
      chk("reset_rdata", 0, rsp_rdata[0], 32'h0);
      chk("reset_we",    0, 32'(rsp_we[0]), 32'd0);
      chk("reset_ready", 0, 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;

      // reset while a store is waiting: store must be lost
      access(0, 1'b1, 9'h010, 32'h1111_1111, 4'hF, rd, w, lat);
      send(0, 1'b1, 9'h010, 32'hDEAD_BEEF, 4'hF, acc);
      #2; rst[0] = 1'b1;
      #1;
      chk("rst_req_ready", 0, 32'(req_ready[0]), 32'd1);
      chk("rst_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
      @(posedge clk); @(posedge clk); #1; rst[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      access(0, 1'b0, 9'h010, 32'h0, 4'h0, rd, w, lat);
      chk("t1_load_prestore", 0, rd, 32'h1111_1111);

      // store/load latency
      access(0, 1'b1, 9'h005, 32'h1234_5678, 4'hF, rd, w, lat);
      chk("t2_store_lat", 0, 32'(lat), 32'd3);
      chk("t2_store_rd",  0, rd, 32'h0);
      chk("t2_store_we",  0, 32'(w), 32'd1);
      access(0, 1'b0, 9'h005, 32'h0, 4'h0, rd, w, lat);
      chk("t2_load_rd", 0, rd, 32'h1234_5678);
      chk("t2_load_we", 0, 32'(w), 32'd0);

      // byte lanes
      access(0, 1'b1, 9'h005, 32'hAABB_CCDD, 4'b0101, rd, w, lat);
      access(0, 1'b1, 9'h005, 32'hAABB_CCDD, 4'b0000, rd, w, lat);
      chk("t3_be0_we", 0, 32'(w), 32'd1);
      access(0, 1'b0, 9'h005, 32'h0, 4'h0, rd, w, lat);
      chk("t3_lanes", 0, rd, 32'h12BB_56DD);

      // response backpressure
      rsp_ready[0] = 1'b0;
      send(0, 1'b0, 9'h005, 32'h0, 4'h0, acc);
      wait_rsp(0, t, rd, w);
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", 0, 32'(rsp_valid[0]), 32'd1);
         chk("t4_hold_rdata", 0, rsp_rdata[0], 32'h12BB_56DD);
         chk("t4_ready_low",  0, 32'(req_ready[0]), 32'd0);
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      chk("t4_ready_resp", 0, 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_one_xfer", 0, 32'(rsp_valid[0]), 32'd0);
      @(posedge clk); #1;

      // back-to-back on the zero-wait instance
      for (int a = 0; a < 3; a++) access(1, 1'b1, 9'(a), 32'(a + 1), 4'hF, rd, w, lat);
      n = 0; idx = 0;
      req_we[1] = 1'b0; req_addr[1] = 9'h000; req_valid[1] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rsp_valid[1] === 1'b1 && n < 3) begin
            rise[n] = cyc; dat[n] = rsp_rdata[1]; n++;
            chk("t5_ready_pulse", 1, 32'(req_ready[1]), 32'd1);
         end
         a2 = (req_valid[1] === 1'b1) && (req_ready[1] === 1'b1);
         @(posedge clk); #1;
         if (a2) begin
            idx++;
            if (idx < 3) req_addr[1] = 9'(idx);
            else req_valid[1] = 1'b0;
         end
      end
      req_valid[1] = 1'b0;
      chk("t5_count", 1, 32'(n), 32'd3);
      if (n == 3) begin
         chk("t5_d0", 1, dat[0], 32'd1);
         chk("t5_d1", 1, dat[1], 32'd2);
         chk("t5_d2", 1, dat[2], 32'd3);
         chk("t5_gap1", 1, 32'(rise[1] - rise[0]), 32'd2);
         chk("t5_gap2", 1, 32'(rise[2] - rise[1]), 32'd2);
      end

      // maximum wait states
      send(2, 1'b1, 9'h033, 32'hCAFE_F00D, 4'hF, acc);
      t = -1;
      for (int c = 0; c < 40 && t < 0; c++) begin
         @(negedge clk);
         if (rsp_valid[2] === 1'b1) t = cyc;
         else chk("t6_busy_wait", 2, 32'(busy[2]), 32'd1);
      end
      chk("t6_latency", 2, 32'(t - acc), 32'd16);
      chk("t6_busy_resp", 2, 32'(busy[2]), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6_busy_done", 2, 32'(busy[2]), 32'd0);
      @(posedge clk); #1;

      // randomized traffic on every instance
      for (int k = 0; k < 3; k++) begin
         for (int a = 0; a < 8; a++) access(k, 1'b1, 9'(a), $urandom, 4'hF, rd, w, lat);
         run_random(k, (k == 2) ? 400 : 300);
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
         req_wdata[k] = '0; req_be[k] = '0; rsp_ready[k] = 1'b1;
      end
      fork
         begin
            while (!done) begin
               @(negedge clk);
               if (!done) check_all();
            end
         end
         begin
            main_seq();
            done = 1;
         end
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (slave) end of the CPU MEM-stage data-memory interface.
- Accepts one load or store request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Performs the access on an internal word-addressed array with byte-lane write enables, then returns read data or a store acknowledge over a valid/ready response channel.
- Replaces the zero-wait memory so the pipeline can be exercised against slow data memory. The CPU stalls on !req_ready or !rsp_valid.

Parameters:
- data_width, 32, word width in bits (multiple of 8).
- data_words, 512, array depth in words.
- data_addr_width, 9, word-address width (= clog2(data_words)).
- wait_states, 2, extra cycles per access; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  data_addr_width  word address.
- req_wdata  in  data_width  store data.
- req_be  in  data_width/8  byte-lane enables for stores; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  data_width  load data; 0 for stores.
- rsp_we  out  1  echo of req_we for the access being answered.
- busy  out  1  state != IDLE.

Behaviour:
- Registered state: state {IDLE, WAIT, RESP}, 4-bit wait counter cnt, request holding registers (we, addr, wdata, be), rsp_rdata, rsp_we.
- Reset (asynchronous, any state):
  - state = IDLE; cnt, rsp_rdata, rsp_we and holding registers = 0.
  - Outputs during and after reset: req_ready = 1, rsp_valid = 0, busy = 0.
  - Array contents are not cleared.
  - Reset during WAIT drops the pending access; a pending store is not committed.
- Handshake: a transfer occurs on a rising edge where the valid and ready of the same channel are both 1.
- req_ready = (state == IDLE) | (state == RESP & rsp_ready). This is combinational from rsp_ready, with no other input paths.
- rsp_valid = (state == RESP). Once asserted, rsp_valid, rsp_rdata and rsp_we hold stable until the response transfer.
- IDLE: on req_valid, capture the request, set cnt = wait_states, go to WAIT. Otherwise stay.
- WAIT: if cnt != 0, decrement cnt and stay. If cnt == 0, perform the access on this edge and go to RESP.
  - Load: rsp_rdata <= mem[addr].
  - Store: mem[addr] lanes with be[i] = 1 <= wdata lanes; rsp_rdata <= 0.
  - rsp_we <= captured we.
- RESP: on rsp_ready & req_valid, the response retires and a new request is captured on the same edge; go to WAIT with cnt = wait_states. On rsp_ready alone, go to IDLE. Otherwise hold.
- Latency: rsp_valid rises exactly wait_states+1 cycles after the accepting edge. Back-to-back throughput is one access per wait_states+2 cycles.
- Store with req_be = 0: no array change; still acknowledged normally.
- Load after store to the same address: returns the stored data, because the store commits before its response is visible.
- Inputs are ignored outside a request transfer. req_addr/req_wdata/req_be changing during WAIT has no effect.
- Address is always in range (data_words = 2^data_addr_width). No error response exists.

Test Plan:
1. Reset mid-access:
   - Store addr 0x010 = 0xDEADBEEF, be = 4'hF, wait_states = 2; assert reset while in WAIT.
   - Required: rsp_valid never rises, req_ready = 1 immediately.
   - Subsequent load of 0x010 returns the pre-store contents.
2. Store/load latency:
   - Store 0x005 = 0x12345678, be = 4'hF, rsp_ready held 1.
   - Required: rsp_valid rises 3 cycles after accept with rsp_we = 1, rsp_rdata = 0.
   - Load 0x005 returns 0x12345678 with rsp_we = 0.
3. Byte lanes:
   - After test 2, store 0x005 = 0xAABBCCDD with be = 4'b0101, then with be = 4'b0000.
   - Required: load returns 0x12BB56DD.
4. Response backpressure:
   - Load with rsp_ready = 0 for 5 cycles after rsp_valid rises.
   - Required: rsp_valid and rsp_rdata stay stable, req_ready = 0 throughout, one transfer when rsp_ready = 1.
5. Back-to-back requests:
   - With req_valid and rsp_ready held 1, issue loads to 0x000, 0x001, 0x002 containing 1, 2, 3, wait_states = 0.
   - Required: responses 1, 2, 3 on consecutive 2-cycle intervals; req_ready pulses in each RESP cycle.
6. Wait-state range:
   - Run with wait_states = 15.
   - Required: rsp_valid rises exactly 16 cycles after accept; busy = 1 from accept until the response transfer.
